nibble_serial_adder: RTL and testbench

Sequencing controller that adds two wide operands of 4·NIBBLES bits over NIBBLES clock cycles, using one shared 4-bit ripple adder slice per cycle and chaining the carry between nibbles. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It lets wide additions reuse the team's small 4-bit adder datapath instead of instantiating a full-width adder.

---
 rtl/serial_add_pkg.sv | 14 +
 rtl/adder4_slice.sv | 18 +
 rtl/nibble_serial_adder.sv | 106 ++++++++++
 tb/tb_nibble_serial_adder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/adder4_slice.sv
// Purely combinational 4-bit ripple adder slice reused by the serial controller.
module adder4_slice
  import serial_add_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    cin,
  output nibble_t s,
  output logic    cout
);

  logic [NIBBLE_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
  assign s     = total[NIBBLE_W-1:0];
  assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two 4*NIBBLES-bit operands one nibble per cycle through a shared 4-bit slice.
// Optional SERIAL_ADD_SUB_EN adds a sub port that turns the operation into A - B - CIN.
module nibble_serial_adder
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                      sub,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] s,
  output logic                      cout,
  output logic                      busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t           state, state_next;
  logic [W-1:0]     a_r, b_r;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             last_nibble;
  logic             sub_sel;
  nibble_t          slice_a, slice_b, slice_s;
  logic             slice_cout;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign last_nibble = (idx == IDX_W'(NIBBLES - 1));
  assign slice_a     = a_r[NIBBLE_W*idx +: NIBBLE_W];
  assign slice_b     = b_r[NIBBLE_W*idx +: NIBBLE_W];

  adder4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)    state_next = RUN;
      RUN:     if (last_nibble) state_next = DONE;
      DONE:    if (out_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Subtraction reuses the adder: A + ~B + ~CIN equals A - B - CIN modulo 2^W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= sub_sel ? ~b : b;
            carry <= sub_sel ? ~cin : cin;
            idx   <= '0;
            s     <= '0;
            cout  <= 1'b0;
          end
        end
        RUN: begin
          s[NIBBLE_W*idx +: NIBBLE_W] <= slice_s;
          carry                       <= slice_cout;
          if (last_nibble) cout <= slice_cout;
          else             idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Table-driven, scoreboarded bench for nibble_serial_adder with NIBBLES = 4.
// Subtraction vectors run only when SERIAL_ADD_SUB_EN is defined.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, s;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W:0]   exp;
  } vec_t;

  vec_t       vecs[$];
  logic [W:0] sb_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, drives one operand set through the accept edge, then pushes the expectation.
  task automatic apply_stimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic vcin, input logic vsub, input logic [W:0] vexp);
    int k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    check_output("in_ready_before_accept", 32'(in_ready), 32'd1);
    a        = va;
    b        = vb;
    cin      = vcin;
`ifdef SERIAL_ADD_SUB_EN
    sub      = vsub;
`else
    if (vsub) $display("[TB] subtract vector issued without sub support");
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb_q.push_back(vexp);
  endtask

  // Waits for the result, checks latency and value, then completes the output handshake.
  task automatic collect(input string name, input int exp_latency);
    int         lat = 0;
    logic [W:0] exp;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (exp_latency >= 0) check_output({name, "_latency"}, 32'(lat), 32'(exp_latency));
    if (sb_q.size() == 0) begin
      $display("[TB] FAIL %s_scoreboard: got empty expected entry", name);
      n_checks++;
      return;
    end
    exp = sb_q.pop_front();
    check_output({name, "_result"}, 32'({cout, s}), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output({name, "_out_valid_after_hs"}, 32'(out_valid), 32'd0);
    check_output({name, "_in_ready_after_hs"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W:0] hold_exp;
    int         acc_cyc[3];
    int         accepted, done, cyc;
    bit         pending;

    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 1'b0, 17'h0_0002});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1_FFFF});
    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 17'h0_5555});
    vecs.push_back('{16'h8000, 16'h8000, 1'b1, 1'b0, 17'h1_0001});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 17'h1_0001 - 17'h1_0000 + 17'h0_1000});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0_FFFE});
    vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 17'h1_0002});
    vecs.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 17'h1_0001});
    vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b0, 17'h0_000C});
    sub = 1'b0;
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_in_ready", 32'(in_ready), 32'd1);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_sum", 32'({cout, s}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp);
      check_output($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      collect($sformatf("vec%0d", i), NIBBLES);
    end

    // Back-pressure: DONE must hold while new operands wait on in_valid.
    apply_stimulus(16'h0F0F, 16'h0101, 1'b0, 1'b0, 17'h0_1010);
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    hold_exp = sb_q.pop_front();
    a        = 16'hAAAA;
    b        = 16'h5555;
    cin      = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_output("bp_out_valid", 32'(out_valid), 32'd1);
      check_output("bp_in_ready", 32'(in_ready), 32'd0);
      check_output("bp_result", 32'({cout, s}), 32'(hold_exp));
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("bp_idle_after_hs", 32'(in_ready), 32'd1);
    check_output("bp_not_yet_accepted", 32'(busy), 32'd0);
    tick();
    in_valid = 1'b0;
    check_output("bp_new_accepted", 32'(busy), 32'd1);
    sb_q.push_back(17'h0_FFFF);
    collect("bp_next", NIBBLES);

    // Reset in the middle of RUN aborts and clears everything.
    apply_stimulus(16'h1234, 16'h1111, 1'b0, 1'b0, 17'h0_2345);
    void'(sb_q.pop_back());
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_output("midrst_in_ready", 32'(in_ready), 32'd1);
    check_output("midrst_out_valid", 32'(out_valid), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_sum", 32'({cout, s}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    apply_stimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h0_0100);
    collect("after_rst", NIBBLES);

    // Back-to-back: in_valid and out_ready held high, accepts every NIBBLES+2 edges.
    out_ready = 1'b1;
    accepted  = 0;
    done      = 0;
    cyc       = 0;
    pending   = 1'b0;
    while (done < 3 && cyc < 60) begin
      if (in_ready && accepted < 3) begin
        a        = vecs[accepted + 1].a;
        b        = vecs[accepted + 1].b;
        cin      = vecs[accepted + 1].cin;
        in_valid = 1'b1;
        pending  = 1'b1;
      end else if (accepted >= 3) begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (sb_q.size() > 0) check_output("b2b_result", 32'({cout, s}), 32'(sb_q.pop_front()));
        else check_output("b2b_scoreboard", 32'd0, 32'd1);
        done++;
      end
      tick();
      cyc++;
      if (pending) begin
        acc_cyc[accepted] = cyc;
        if (accepted > 0)
          check_output("b2b_spacing", 32'(cyc - acc_cyc[accepted - 1]), 32'(NIBBLES + 2));
        sb_q.push_back(vecs[accepted + 1].exp);
        accepted++;
        pending = 1'b0;
      end
    end
    check_output("b2b_done_count", 32'(done), 32'd3);
    out_ready = 1'b0;
    in_valid  = 1'b0;

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
